// File: rtl/fp_op_arbiter.sv
// Round-robin arbiter that shares one multi-cycle FPU between REQ_COUNT requesters,
// with a completion watchdog and sticky sNaN/qNaN flags.
module fp_op_arbiter #(
  parameter int REQ_COUNT = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [REQ_COUNT-1:0]    req_valid_i,
  input  logic [3*REQ_COUNT-1:0]  req_op_i,
  input  logic [32*REQ_COUNT-1:0] req_a_i,
  input  logic [32*REQ_COUNT-1:0] req_b_i,
  output logic [REQ_COUNT-1:0]    req_ready_o,
  output logic                    fpu_start_o,
  output logic [2:0]              fpu_op_o,
  output logic [31:0]             fpu_a_o,
  output logic [31:0]             fpu_b_o,
  input  logic                    fpu_done_i,
  input  logic [31:0]             fpu_result_i,
  input  logic                    fpu_qnan_i,
  input  logic                    fpu_snan_i,
  output logic [REQ_COUNT-1:0]    resp_valid_o,
  output logic [31:0]             resp_result_o,
  output logic                    resp_error_o,
  input  logic                    flag_clear_i,
  output logic                    flag_invalid_o,
  output logic                    flag_qnan_o,
  output logic                    busy_o
);

  localparam int PW = (REQ_COUNT > 2) ? 2 : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(REQ_COUNT - 1);
  localparam logic [31:0]   CANON_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   result_q, result_d;
  logic          error_q, error_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_inv_q, flag_inv_d;
  logic          flag_qnan_q, flag_qnan_d;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] cand;

  // Scan from the pointer downward so the first valid at/after rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr_q) + k) % REQ_COUNT);
      if (req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    error_d      = error_q;
    cnt_d        = cnt_q;
    req_ready_o  = '0;
    resp_valid_o = '0;
    fpu_start_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = ISSUE;
          grant_d = pick_idx;
          for (int i = 0; i < REQ_COUNT; i++) begin
            if (PW'(i) == pick_idx) begin
              req_ready_o[i] = !reset_i;
              op_d           = req_op_i[3*i +: 3];
              a_d            = req_a_i[32*i +: 32];
              b_d            = req_b_i[32*i +: 32];
            end
          end
        end
      end
      ISSUE: begin
        fpu_start_o = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // A done on the final watchdog cycle still counts as a normal completion.
        if (fpu_done_i) begin
          result_d = fpu_result_i;
          error_d  = 1'b0;
          state_d  = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          result_d = CANON_QNAN;
          error_d  = 1'b1;
          state_d  = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESPOND: begin
        for (int i = 0; i < REQ_COUNT; i++) begin
          if (PW'(i) == grant_q) begin
            resp_valid_o[i] = 1'b1;
          end
        end
        rr_ptr_d = (grant_q == PTR_LAST) ? '0 : grant_q + PW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear first, then OR in a coincident NaN report so a set is never lost.
  always_comb begin
    flag_inv_d  = flag_clear_i ? 1'b0 : flag_inv_q;
    flag_qnan_d = flag_clear_i ? 1'b0 : flag_qnan_q;
    if ((state_q == WAIT) && fpu_done_i) begin
      flag_inv_d  = flag_inv_d | fpu_snan_i;
      flag_qnan_d = flag_qnan_d | fpu_qnan_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
      flag_inv_q  <= 1'b0;
      flag_qnan_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
      flag_inv_q  <= flag_inv_d;
      flag_qnan_q <= flag_qnan_d;
    end
  end

  assign fpu_op_o       = op_q;
  assign fpu_a_o        = a_q;
  assign fpu_b_o        = b_q;
  assign resp_result_o  = result_q;
  assign resp_error_o   = error_q;
  assign flag_invalid_o = flag_inv_q;
  assign flag_qnan_o    = flag_qnan_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_fp_op_arbiter.sv
// Bench for fp_op_arbiter: behavioural FPU model, response log and expected-response scoreboard.
module tb_fp_op_arbiter;

  localparam int RC = 2;
  localparam int TO = 8;

  typedef struct packed {
    logic [RC-1:0] vld;
    logic [31:0]   res;
    logic          err;
  } resp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [RC-1:0]   req_valid;
  logic [3*RC-1:0] req_op;
  logic [32*RC-1:0] req_a;
  logic [32*RC-1:0] req_b;
  logic [RC-1:0]   req_ready;
  logic            fpu_start;
  logic [2:0]      fpu_op;
  logic [31:0]     fpu_a, fpu_b;
  logic            fpu_done;
  logic [31:0]     fpu_result;
  logic            fpu_qnan, fpu_snan;
  logic [RC-1:0]   resp_valid;
  logic [31:0]     resp_result;
  logic            resp_error;
  logic            flag_clear;
  logic            flag_invalid, flag_qnan;
  logic            busy;

  int    testsRun = 0;
  int    testsFailed = 0;
  int    cycleCnt = 0;
  int    rdIdx = 0;
  int    fpuLatency = 3;
  bit    fpuHang = 1'b0;
  bit    fpuSnan = 1'b0;
  bit    fpuQnan = 1'b0;
  int    strayReqCnt = 0;
  int    strayDoneCnt;
  resp_t sbq[$];
  resp_t respLog[$];
  resp_t expR, gotR;

  always #5 clk = ~clk;

  fp_op_arbiter #(.REQ_COUNT(RC), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready),
    .fpu_start_o(fpu_start), .fpu_op_o(fpu_op), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b),
    .fpu_done_i(fpu_done), .fpu_result_i(fpu_result), .fpu_qnan_i(fpu_qnan), .fpu_snan_i(fpu_snan),
    .resp_valid_o(resp_valid), .resp_result_o(resp_result), .resp_error_o(resp_error),
    .flag_clear_i(flag_clear), .flag_invalid_o(flag_invalid), .flag_qnan_o(flag_qnan),
    .busy_o(busy)
  );

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  always @(negedge clk) begin
    if (resp_valid !== '0) respLog.push_back({resp_valid, resp_result, resp_error});
  end

  // FPU model: opcode 001 negates A, everything else returns A+B; stray pulses carry both NaN bits.
  initial begin
    fpu_done = 1'b0; fpu_result = '0; fpu_snan = 1'b0; fpu_qnan = 1'b0;
    strayDoneCnt = 0;
    forever begin
      @(negedge clk);
      if (fpu_start === 1'b1 && !fpuHang) begin
        repeat (fpuLatency) @(posedge clk);
        #1;
        fpu_result = (fpu_op == 3'b001) ? (fpu_a ^ 32'h8000_0000) : (fpu_a + fpu_b);
        fpu_snan = fpuSnan; fpu_qnan = fpuQnan; fpu_done = 1'b1;
        @(posedge clk); #1;
        fpu_done = 1'b0; fpu_snan = 1'b0; fpu_qnan = 1'b0;
      end else if (strayReqCnt != strayDoneCnt) begin
        strayDoneCnt++;
        @(posedge clk); #1;
        fpu_result = 32'hDEAD_BEEF; fpu_snan = 1'b1; fpu_qnan = 1'b1; fpu_done = 1'b1;
        @(posedge clk); #1;
        fpu_done = 1'b0; fpu_snan = 1'b0; fpu_qnan = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input int id, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, output bit accepted);
    @(posedge clk); #1;
    req_valid = RC'(1) << id;
    req_op[3*id +: 3] = op;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    accepted = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[id] === 1'b1) begin accepted = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic waitResponse(output bit got);
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (respLog.size() > rdIdx) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({req_ready, fpu_start, resp_valid, resp_error, flag_invalid, flag_qnan, busy} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got rdy=%b start=%b rv=%b err=%b inv=%b qn=%b busy=%b, expected all 0",
               req_ready, fpu_start, resp_valid, resp_error, flag_invalid, flag_qnan, busy);
    end
    testsRun++;
    if ({fpu_op, fpu_a, fpu_b, resp_result} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got op=%h a=%h b=%h res=%h, expected all 0", fpu_op, fpu_a, fpu_b, resp_result);
    end
  endtask

  task automatic test_single();
    bit acc, got;
    fpuLatency = 3;
    applyStimulus(0, 3'b001, 32'h3F80_0000, 32'h0, acc);
    sbq.push_back({2'b01, 32'hBF80_0000, 1'b0});
    testsRun++;
    if (!acc) begin testsFailed++; $display("[TB] FAIL single_ready: got no req_ready[0], expected 1"); end
    @(negedge clk);
    testsRun++;
    if ({fpu_start, fpu_op, fpu_a} !== {1'b1, 3'b001, 32'h3F80_0000}) begin
      testsFailed++;
      $display("[TB] FAIL single_start: got start=%b op=%b a=%h, expected 1 001 3f800000", fpu_start, fpu_op, fpu_a);
    end
    repeat (3) @(negedge clk);
    testsRun++;
    if (resp_valid !== 2'b00) begin testsFailed++; $display("[TB] FAIL single_early: got resp_valid=%b at T+4, expected 00", resp_valid); end
    @(negedge clk);
    testsRun++;
    if ({resp_valid, resp_result, resp_error} !== {2'b01, 32'hBF80_0000, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL single_latency: got rv=%b res=%h err=%b at T+5, expected 01 bf800000 0", resp_valid, resp_result, resp_error);
    end
    waitResponse(got);
    expR = sbq.pop_front();
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL single_resp: got no response, expected %h", expR); end
    else begin
      gotR = respLog[rdIdx]; rdIdx++;
      if (gotR !== expR) begin testsFailed++; $display("[TB] FAIL single_resp: got %h expected %h", gotR, expR); end
    end
  endtask

  task automatic test_round_robin();
    bit seen, got;
    int expGrant;
    int acceptCyc[4];
    fpuLatency = 1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req_valid = 2'b11; req_op = '0;
    req_a = {32'd10, 32'd1}; req_b = {32'd20, 32'd2};
    expGrant = 0;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (req_ready !== '0) begin seen = 1'b1; break; end
      end
      acceptCyc[g] = cycleCnt;
      testsRun++;
      if (!seen || req_ready !== (RC'(1) << expGrant)) begin
        testsFailed++;
        $display("[TB] FAIL rr_grant%0d: got req_ready=%b, expected %b", g, req_ready, RC'(1) << expGrant);
      end
      sbq.push_back({RC'(1) << expGrant, (expGrant == 1) ? 32'd30 : 32'd3, 1'b0});
      expGrant = 1 - expGrant;
    end
    @(posedge clk); #1 req_valid = '0;
    for (int g = 1; g < 4; g++) begin
      testsRun++;
      if (acceptCyc[g] - acceptCyc[g-1] != 4) begin
        testsFailed++;
        $display("[TB] FAIL rr_spacing%0d: got %0d cycles between accepts, expected 4", g, acceptCyc[g] - acceptCyc[g-1]);
      end
    end
    for (int r = 0; r < 4; r++) begin
      waitResponse(got);
      expR = sbq.pop_front();
      testsRun++;
      if (!got) begin testsFailed++; $display("[TB] FAIL rr_resp%0d: got no response, expected %h", r, expR); end
      else begin
        gotR = respLog[rdIdx]; rdIdx++;
        if (gotR !== expR) begin testsFailed++; $display("[TB] FAIL rr_resp%0d: got %h expected %h", r, gotR, expR); end
      end
    end
  endtask

  task automatic test_snan_flag();
    bit acc, got;
    fpuLatency = 2;
    for (int s = 0; s < 3; s++) begin
      fpuSnan = (s != 1);
      fpuQnan = (s == 1);
      if (s == 1) begin
        applyStimulus(1, 3'b000, 32'd100, 32'd1, acc);
        sbq.push_back({2'b10, 32'd101, 1'b0});
      end else if (s == 0) begin
        applyStimulus(0, 3'b000, 32'd5, 32'd6, acc);
        sbq.push_back({2'b01, 32'd11, 1'b0});
      end else begin
        applyStimulus(0, 3'b000, 32'd2, 32'd3, acc);
        sbq.push_back({2'b01, 32'd5, 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1 flag_clear = 1'b1;
        @(posedge clk); #1 flag_clear = 1'b0;
      end
      waitResponse(got);
      expR = sbq.pop_front();
      testsRun++;
      if (!got) begin testsFailed++; $display("[TB] FAIL flag_resp%0d: got no response, expected %h", s, expR); end
      else begin
        gotR = respLog[rdIdx]; rdIdx++;
        if (gotR !== expR) begin testsFailed++; $display("[TB] FAIL flag_resp%0d: got %h expected %h", s, gotR, expR); end
      end
      @(negedge clk);
      testsRun++;
      if ({flag_invalid, flag_qnan} !== ((s == 0) ? 2'b10 : (s == 1) ? 2'b11 : 2'b10)) begin
        testsFailed++;
        $display("[TB] FAIL flag_step%0d: got inv=%b qnan=%b, expected %b", s, flag_invalid, flag_qnan,
                 (s == 0) ? 2'b10 : (s == 1) ? 2'b11 : 2'b10);
      end
    end
    fpuSnan = 1'b0; fpuQnan = 1'b0;
    @(posedge clk); #1 flag_clear = 1'b1;
    @(posedge clk); #1 flag_clear = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({flag_invalid, flag_qnan} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL flag_clear: got inv=%b qnan=%b, expected 00", flag_invalid, flag_qnan);
    end
  endtask

  task automatic test_timeout();
    bit acc, got;
    fpuHang = 1'b1;
    applyStimulus(1, 3'b000, 32'd7, 32'd8, acc);
    sbq.push_back({2'b10, 32'h7FC0_0000, 1'b1});
    @(negedge clk);
    testsRun++;
    if (fpu_start !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_start: got fpu_start=%b, expected 1", fpu_start); end
    repeat (TO) @(negedge clk);
    testsRun++;
    if (resp_valid !== 2'b00) begin testsFailed++; $display("[TB] FAIL to_early: got resp_valid=%b, expected 00", resp_valid); end
    @(negedge clk);
    testsRun++;
    if ({resp_valid, resp_result, resp_error} !== {2'b10, 32'h7FC0_0000, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL to_abort: got rv=%b res=%h err=%b, expected 10 7fc00000 1", resp_valid, resp_result, resp_error);
    end
    waitResponse(got);
    expR = sbq.pop_front();
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL to_resp: got no response, expected %h", expR); end
    else begin
      gotR = respLog[rdIdx]; rdIdx++;
      if (gotR !== expR) begin testsFailed++; $display("[TB] FAIL to_resp: got %h expected %h", gotR, expR); end
    end
    fpuHang = 1'b0;
    strayReqCnt++;
    repeat (6) @(negedge clk);
    testsRun++;
    if (respLog.size() != rdIdx || {flag_invalid, flag_qnan} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL to_late_done: got %0d extra responses, flags %b%b, expected 0 and 00",
               respLog.size() - rdIdx, flag_invalid, flag_qnan);
    end
  endtask

  task automatic test_stray_done();
    bit acc, got;
    fpuLatency = 2; fpuQnan = 1'b1;
    applyStimulus(0, 3'b000, 32'd1, 32'd1, acc);
    sbq.push_back({2'b01, 32'd2, 1'b0});
    waitResponse(got);
    fpuQnan = 1'b0;
    expR = sbq.pop_front();
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL stray_setup: got no response, expected %h", expR); end
    else begin
      gotR = respLog[rdIdx]; rdIdx++;
      if (gotR !== expR) begin testsFailed++; $display("[TB] FAIL stray_setup: got %h expected %h", gotR, expR); end
    end
    repeat (2) @(negedge clk);
    strayReqCnt++;
    repeat (6) @(negedge clk);
    testsRun++;
    if (respLog.size() != rdIdx) begin
      testsFailed++;
      $display("[TB] FAIL stray_resp: got %0d responses to stray done, expected 0", respLog.size() - rdIdx);
    end
    testsRun++;
    if ({flag_invalid, flag_qnan} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL stray_flags: got inv=%b qnan=%b, expected 01", flag_invalid, flag_qnan);
    end
  endtask

  task automatic test_reset_in_wait();
    bit acc, got, seen;
    fpuLatency = 1;
    applyStimulus(0, 3'b000, 32'd40, 32'd2, acc);
    sbq.push_back({2'b01, 32'd42, 1'b0});
    waitResponse(got);
    expR = sbq.pop_front();
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL rw_setup: got no response, expected %h", expR); end
    else begin
      gotR = respLog[rdIdx]; rdIdx++;
      if (gotR !== expR) begin testsFailed++; $display("[TB] FAIL rw_setup: got %h expected %h", gotR, expR); end
    end
    fpuLatency = 10; fpuSnan = 1'b1;
    applyStimulus(0, 3'b001, 32'h1234_5678, 32'h0000_0042, acc);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({busy, fpu_start, resp_valid, req_ready, fpu_op, fpu_a, fpu_b, flag_invalid, flag_qnan} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL rw_reset: got busy=%b start=%b rv=%b op=%h a=%h b=%h inv=%b qn=%b, expected all 0",
               busy, fpu_start, resp_valid, fpu_op, fpu_a, fpu_b, flag_invalid, flag_qnan);
    end
    repeat (12) @(negedge clk);
    testsRun++;
    if (respLog.size() != rdIdx || flag_invalid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rw_dropped: got %0d responses, inv=%b after late done, expected 0 and 0",
               respLog.size() - rdIdx, flag_invalid);
    end
    fpuSnan = 1'b0; fpuLatency = 1;
    @(posedge clk); #1;
    req_valid = 2'b11; req_op = '0;
    req_a = {32'd9, 32'd4}; req_b = {32'd1, 32'd5};
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready !== '0) begin seen = 1'b1; break; end
    end
    testsRun++;
    if (!seen || req_ready !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL rw_rrptr: got req_ready=%b, expected 01", req_ready);
    end
    sbq.push_back({2'b01, 32'd9, 1'b0});
    @(posedge clk); #1 req_valid = '0;
    waitResponse(got);
    expR = sbq.pop_front();
    testsRun++;
    if (!got) begin testsFailed++; $display("[TB] FAIL rw_resp: got no response, expected %h", expR); end
    else begin
      gotR = respLog[rdIdx]; rdIdx++;
      if (gotR !== expR) begin testsFailed++; $display("[TB] FAIL rw_resp: got %h expected %h", gotR, expR); end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; flag_clear = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_snan_flag();
    test_timeout();
    test_stray_done();
    test_reset_in_wait();
    repeat (4) @(negedge clk);
    testsRun++;
    if (respLog.size() != rdIdx) begin
      testsFailed++;
      $display("[TB] FAIL extra_resp: got %0d unexpected responses, expected 0", respLog.size() - rdIdx);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fp_op_arbiter.md
# fp_op_arbiter

Shares one multi-cycle floating-point unit (negate/abs/add/sub/mul/div datapath with start/done handshake) between `REQ_COUNT` requesters, e.g. the COP1 issue stage and the FP exception/microcode path. Round-robin grant, one operation in flight, timeout watchdog. Responses return one-hot by requester. Sticky IEEE-754 invalid (sNaN) and quiet-NaN flags are accumulated until cleared.

## Interface
Parameters:
- `REQ_COUNT`, 2: number of requesters (2..4).
- `TIMEOUT`, 64: max cycles waited for `fpu_done` before abort (≥2).

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  REQ_COUNT  per-requester request.
- `req_op`  in  3*REQ_COUNT  opcode per requester; slice i = [3i+2:3i].
- `req_a`  in  32*REQ_COUNT  operand A per requester.
- `req_b`  in  32*REQ_COUNT  operand B per requester.
- `req_ready`  out  REQ_COUNT  one-hot accept strobe; request i consumed when `req_valid[i] & req_ready[i]`.
- `fpu_start`  out  1  one-cycle start pulse to shared unit.
- `fpu_op`  out  3  latched opcode.
- `fpu_a`, `fpu_b`  out  32  latched operands.
- `fpu_done`  in  1  unit completion strobe.
- `fpu_result`  in  32  unit result, valid with `fpu_done`.
- `fpu_qnan`, `fpu_snan`  in  1  unit NaN classification, valid with `fpu_done`.
- `resp_valid`  out  REQ_COUNT  one-hot response strobe (1 cycle).
- `resp_result`  out  32  result for responding requester.
- `resp_error`  out  1  response is a timeout abort.
- `flag_clear`  in  1  clears sticky flags.
- `flag_invalid`, `flag_qnan`  out  1  sticky flags.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: if any `req_valid`, pick first set bit at/after round-robin pointer `rr_ptr` (wrapping modulo REQ_COUNT); assert that `req_ready` bit combinationally; latch op/A/B and grant id; go ISSUE. No valid → stay.
- ISSUE: `fpu_start`=1 for exactly one cycle; clear timeout counter; go WAIT.
- WAIT: count cycles. On `fpu_done`: latch `fpu_result`, set `resp_error`=0, go RESPOND. If counter reaches TIMEOUT−1 without done: `resp_result`=32'h7FC00000 (canonical qNaN), `resp_error`=1, go RESPOND.
- RESPOND: `resp_valid[grant_id]`=1 one cycle; `rr_ptr` ← grant_id+1 mod REQ_COUNT; go IDLE.
- `fpu_done` outside WAIT is ignored (no flag update, no response).
- Sticky flags: on accepted `fpu_done` in WAIT, `flag_invalid` |= `fpu_snan`, `flag_qnan` |= `fpu_qnan`. `flag_clear` clears both; if clear and set coincide, set wins.
- `fpu_op`/`fpu_a`/`fpu_b` hold latched values from ISSUE until next grant.
- `req_ready` is zero in all states but IDLE; at most one bit high.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `fpu_start`=0, `fpu_op`=0, `fpu_a`=`fpu_b`=0, `resp_valid`=0, `resp_result`=0, `resp_error`=0, flags 0, `busy`=0.
- Reset asserted mid-operation: return to IDLE next edge; in-flight op dropped, no response issued; late `fpu_done` afterward ignored.
- Latency: accept at cycle T, `fpu_start` at T+1, done at T+1+L (L≥1), `resp_valid` at T+2+L. Back-to-back accept earliest at T+3+L.
- Timeout: `fpu_done` at cycle count TIMEOUT−1 in WAIT (same edge) is treated as done, not timeout.
- Throughput: one op per (L+3) cycles.

## Test plan
- Single request: `req_valid`=01, op=3'b001, A=32'h3F800000, unit done after 3 cycles with result 32'hBF800000 → `req_ready`=01 at T, `fpu_start` at T+1, `resp_valid`=01 with 32'hBF800000 at T+5, `resp_error`=0.
- Round robin: both valid continuously, rr_ptr=0 → grants 0,1,0,1; no requester granted twice in a row.
- sNaN flag: result with `fpu_snan`=1 → `flag_invalid`=1 after response, stays 1 across next clean op; `flag_clear` pulse → 0; clear and snan same cycle → 1.
- Timeout: TIMEOUT=8, unit never asserts done → `resp_valid` 8 cycles after start+1, `resp_result`=32'h7FC00000, `resp_error`=1; later stray `fpu_done` ignored.
- Reset in WAIT: assert `reset` 2 cycles after `fpu_start` → all outputs at reset values next cycle, no `resp_valid`, `rr_ptr`=0.
- Stray done in IDLE with `fpu_snan`=1 → no response, flags unchanged.
